load_queue_scheduler: RTL and testbench

LOAD_QUEUE_SCHEDULER -- requirements
Module: load_queue_scheduler

---
 rtl/load_queue_scheduler.sv | 120 ++++++++++++
 tb/tb_load_queue_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_queue_scheduler.sv
// Load queue: FIFO of dispatched loads, issued one at a time to memory, then broadcast on the CDB.
// Optional flush port is enabled by defining LOAD_QUEUE_FLUSH_EN.
module load_queue_scheduler #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
`ifdef LOAD_QUEUE_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_type,
    input  logic [31:0] in_addr,
    input  logic [5:0]  in_rob,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic        cdb_req,
    input  logic        cdb_grant,
    output logic [5:0]  cdb_rob,
    output logic [31:0] cdb_data,
    output logic        busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, MEM, CDB} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               flush_i;
    logic               push, pop;

    logic [31:0]        q_addr [DEPTH];
    logic [2:0]         q_type [DEPTH];
    logic [5:0]         q_rob  [DEPTH];

    function automatic logic [31:0] format_load(input logic [2:0] t, input logic [31:0] d);
        logic [31:0] r;
        case (t)
            3'b000:  r = {{24{d[7]}}, d[7:0]};
            3'b001:  r = {{16{d[15]}}, d[15:0]};
            3'b100:  r = {24'b0, d[7:0]};
            3'b101:  r = {16'b0, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

`ifdef LOAD_QUEUE_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // in_ready looks at count alone, so a same-cycle pop never opens a slot for a push
    assign in_ready = (count < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready && !flush_i;
    assign pop      = (state_q == MEM) && mem_ack && !flush_i;

    assign mem_req  = (state_q == MEM);
    assign mem_addr = (state_q == MEM) ? q_addr[rd_ptr] : 32'd0;
    assign cdb_req  = (state_q == CDB);
    assign busy     = (count != '0) || (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count != '0) state_d = MEM;
            MEM:     if (mem_ack)     state_d = CDB;
            CDB:     if (cdb_grant)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            cdb_rob  <= '0;
            cdb_data <= '0;
        end else begin
            state_q <= state_d;
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
            // Result is captured once and held until the CDB grant arrives
            if (pop) begin
                cdb_rob  <= q_rob[rd_ptr];
                cdb_data <= format_load(q_type[rd_ptr], mem_data);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            q_addr[wr_ptr] <= in_addr;
            q_type[wr_ptr] <= in_type;
            q_rob[wr_ptr]  <= in_rob;
        end
    end

endmodule

// File: tb/tb_load_queue_scheduler.sv
// Directed bench for load_queue_scheduler: table of single loads plus multi-cycle corner sequences.
module tb_load_queue_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_type = 3'b0;
    logic [31:0] in_addr = 32'b0;
    logic [5:0]  in_rob = 6'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data = 32'b0;
    logic        cdb_req;
    logic        cdb_grant = 1'b0;
    logic [5:0]  cdb_rob;
    logic [31:0] cdb_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    load_queue_scheduler #(.DEPTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
`ifdef LOAD_QUEUE_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_type   (in_type),
        .in_addr   (in_addr),
        .in_rob    (in_rob),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .cdb_req   (cdb_req),
        .cdb_grant (cdb_grant),
        .cdb_rob   (cdb_rob),
        .cdb_data  (cdb_data),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [5:0]  rob;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [2:0] t, input logic [31:0] a, input logic [5:0] r);
        in_valid = 1'b1;
        in_type  = t;
        in_addr  = a;
        in_rob   = r;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_mem();
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        if (!mem_req) begin
            checks++;
            errors++;
            $display("FAIL wait_mem_req: got timeout expected mem_req");
        end
    endtask

    // One load with zero-wait ack and grant; checks every edge of the minimum-latency path
    task automatic run_single(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        push(v.typ, v.addr, v.rob);
        chk({tag, "_memreq_e0"}, 32'(mem_req), 32'd0);
        chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
        tick();
        chk({tag, "_memreq_e1"}, 32'(mem_req), 32'd1);
        chk({tag, "_memaddr"}, mem_addr, v.addr);
        mem_ack  = 1'b1;
        mem_data = v.data;
        tick();
        mem_ack = 1'b0;
        chk({tag, "_cdbreq_e2"}, 32'(cdb_req), 32'd1);
        chk({tag, "_memreq_e2"}, 32'(mem_req), 32'd0);
        chk({tag, "_cdbrob"}, 32'(cdb_rob), 32'(v.rob));
        chk({tag, "_cdbdata"}, cdb_data, v.exp);
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        chk({tag, "_cdbreq_e3"}, 32'(cdb_req), 32'd0);
        chk({tag, "_busy_e3"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{3'b000, 32'h0000_0010, 6'd5,  32'h0000_00F0, 32'hFFFF_FFF0};
        vecs[1] = '{3'b101, 32'h0000_0020, 6'd1,  32'hABCD_8001, 32'h0000_8001};
        vecs[2] = '{3'b001, 32'h0000_0024, 6'd2,  32'hABCD_8001, 32'hFFFF_8001};
        vecs[3] = '{3'b010, 32'h0000_0028, 6'd3,  32'hABCD_8001, 32'hABCD_8001};
        vecs[4] = '{3'b100, 32'h0000_002C, 6'd4,  32'h1234_5680, 32'h0000_0080};
        vecs[5] = '{3'b000, 32'h0000_0030, 6'd6,  32'h1234_567F, 32'h0000_007F};
        vecs[6] = '{3'b011, 32'h0000_0034, 6'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[7] = '{3'b110, 32'h0000_0038, 6'd8,  32'h8000_0000, 32'h8000_0000};
        vecs[8] = '{3'b111, 32'hFFFF_FFFC, 6'd63, 32'h0000_0001, 32'h0000_0001};
        vecs[9] = '{3'b001, 32'h0000_0040, 6'd9,  32'hFFFF_7FFF, 32'h0000_7FFF};

        // Reset values
        #1 reset = 1'b1;
        repeat (2) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_cdb_req", 32'(cdb_req), 32'd0);
        chk("rst_cdb_rob", 32'(cdb_rob), 32'd0);
        chk("rst_cdb_data", cdb_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) run_single(vecs[i], i);

        // Fill to DEPTH, then a 5th request held through the first pop must be dropped
        for (int i = 1; i <= 4; i++) push(3'b010, 32'h100 + 32'(4 * i), 6'(i));
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_mem_req", 32'(mem_req), 32'd1);
        chk("full_mem_addr", mem_addr, 32'h104);
        in_valid = 1'b1;
        in_type  = 3'b010;
        in_addr  = 32'h999;
        in_rob   = 6'd9;
        mem_ack  = 1'b1;
        mem_data = 32'h1001;
        tick();
        in_valid = 1'b0;
        mem_ack  = 1'b0;
        chk("full_pop_ready", 32'(in_ready), 32'd1);
        chk("full_cdb_rob1", 32'(cdb_rob), 32'd1);
        chk("full_cdb_data1", cdb_data, 32'h1001);
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            wait_mem();
            chk($sformatf("full_addr%0d", i), mem_addr, 32'h100 + 32'(4 * i));
            mem_ack  = 1'b1;
            mem_data = 32'h1000 + 32'(i);
            tick();
            mem_ack = 1'b0;
            chk($sformatf("full_cdb_rob%0d", i), 32'(cdb_rob), 32'(i));
            chk($sformatf("full_cdb_data%0d", i), cdb_data, 32'h1000 + 32'(i));
            cdb_grant = 1'b1;
            tick();
            cdb_grant = 1'b0;
        end
        repeat (3) tick();
        chk("full_drain_mem_req", 32'(mem_req), 32'd0);
        chk("full_drain_busy", 32'(busy), 32'd0);

        // Stalled grant: outputs hold, a queued load does not issue, stray mem_ack ignored
        push(3'b000, 32'h200, 6'd10);
        tick();
        mem_ack  = 1'b1;
        mem_data = 32'h0000_0081;
        tick();
        mem_ack = 1'b0;
        push(3'b101, 32'h204, 6'd11);
        for (int i = 0; i < 10; i++) begin
            mem_ack  = (i == 3);
            mem_data = 32'h5555_5555;
            chk($sformatf("stall_cdb_req%0d", i), 32'(cdb_req), 32'd1);
            chk($sformatf("stall_cdb_rob%0d", i), 32'(cdb_rob), 32'd10);
            chk($sformatf("stall_cdb_data%0d", i), cdb_data, 32'hFFFF_FF81);
            chk($sformatf("stall_mem_req%0d", i), 32'(mem_req), 32'd0);
            tick();
        end
        mem_ack = 1'b0;
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        wait_mem();
        chk("stall_next_addr", mem_addr, 32'h204);
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        chk("grant_in_mem_ignored", 32'(mem_req), 32'd1);
        mem_ack  = 1'b1;
        mem_data = 32'hABCD_FEDC;
        tick();
        mem_ack = 1'b0;
        chk("stall_next_rob", 32'(cdb_rob), 32'd11);
        chk("stall_next_data", cdb_data, 32'h0000_FEDC);
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;

        // Asynchronous reset in the middle of MEM with two entries queued
        push(3'b010, 32'h300, 6'd20);
        push(3'b010, 32'h304, 6'd21);
        chk("mrst_mem_req_before", 32'(mem_req), 32'd1);
        #3 reset = 1'b1;
        #1;
        chk("mrst_mem_req", 32'(mem_req), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_cdb_req", 32'(cdb_req), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        mem_ack = 1'b1;
        cdb_grant = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("mrst_after_mem%0d", i), 32'(mem_req), 32'd0);
            chk($sformatf("mrst_after_cdb%0d", i), 32'(cdb_req), 32'd0);
        end
        mem_ack = 1'b0;
        cdb_grant = 1'b0;

`ifdef LOAD_QUEUE_FLUSH_EN
        // Flush overrides a simultaneous push and abandons the in-flight load
        push(3'b010, 32'h400, 6'd30);
        push(3'b010, 32'h404, 6'd31);
        push(3'b010, 32'h408, 6'd32);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_rob   = 6'd33;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_mem_req", 32'(mem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("flush_idle%0d", i), 32'(mem_req), 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
